inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//   Instruction fetch unit: the initiator side of the instruction-memory read interface.
//   - Owns the PC and drives the word address into the instruction memory.
//   - Captures each returned word, paired with its PC, in a small prefetch FIFO.
//   - Presents entries to decode over a valid/ready handshake; a redirect restarts fetch.
// PARAMETERS
//   RESET_PC    32'h0  PC loaded on reset (word index)
//   FIFO_DEPTH  4      prefetch entries; power of two, >=2
//   CW          3      count width, = $clog2(FIFO_DEPTH+1)
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst_n        in   1   asynchronous reset, active low
//   en           in   1   fetch enable
//   imem_addr    out  32  word address to instruction memory (addr k = k-th word)
//   imem_data    in   32  memory read data; combinational function of imem_addr
//   redirect     in   1   load new PC and flush (branch/jump/exception)
//   redirect_pc  in   32  new PC, word index
//   inst_valid   out  1   FIFO head holds an instruction
//   inst_ready   in   1   decode accepts head this cycle
//   inst         out  32  instruction at FIFO head
//   inst_pc      out  32  PC of inst
//   fifo_count   out  CW  occupied entries, 0..FIFO_DEPTH
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - pc=RESET_PC, FIFO empty, state=IDLE.
//   - inst_valid=0, inst=0, inst_pc=0, fifo_count=0, imem_addr=RESET_PC.
//   - Asserting reset mid-operation discards FIFO contents immediately.
//   imem_addr = pc (registered); no combinational path from any input to imem_addr.
//   Handshake and FIFO:
//   - pop = inst_valid & inst_ready.
//   - FIFO is show-ahead: inst/inst_pc reflect the head combinationally from storage.
//   - inst_valid = (fifo_count!=0).
//   - While inst_valid & !inst_ready, head is held stable until popped, unless redirect.
//   - push = (state==FETCH) & !redirect & (fifo_count<FIFO_DEPTH | pop); writes {pc, imem_data}.
//   - On push, pc <= pc+1, wrapping 32'hFFFF_FFFF -> 0.
//   - Simultaneous push+pop with FIFO full: both occur, count unchanged.
//   - Push+pop with FIFO empty is impossible, since inst_valid=0.
//   FSM (state):
//   - IDLE:  no push. en=1 -> FETCH.
//   - FETCH: push per the rule above.
//            en=0 -> IDLE.
//            en=1 & count==DEPTH & !pop & !redirect -> STALL.
//   - STALL: no push; pc held. en=0 -> IDLE.
//            pop | redirect -> FETCH.
//   - The FIFO continues to drain in every state.
//   Redirect (highest priority, any state):
//   - At the edge: FIFO flushed (count=0), pc <= redirect_pc, no push, pop ignored.
//   - Next state is FETCH if en=1, else IDLE.
//   - The first target instruction is pushed on the following edge.
//   - redirect=1 held on consecutive cycles: the last redirect_pc wins.
//   Latency:
//   - en sampled 1 at edge N -> first push at edge N+1 -> inst_valid=1 after edge N+1.
//   - Steady state with inst_ready=1: one instruction per cycle.
//   - Redirect at edge M -> target visible after edge M+1 (one bubble cycle).
// TESTING
//   Memory model: imem_data = 32'hA000_0000 + imem_addr.
//   T1 reset, en=1, inst_ready=1 -> after 2 edges inst=A0000000 / inst_pc=0,
//      then consecutive pc 1,2,3 each cycle; fifo_count stays at 1.
//   T2 en=1, inst_ready=0 -> fifo_count climbs to 4 and state goes STALL; imem_addr frozen at 4.
//      Then ready=1 -> inst_pc 0,1,2,3,4... with no gaps or duplicates.
//   T3 FIFO holding pc 5..8, redirect=1 with redirect_pc=32'h40 ->
//      next cycle inst_valid=0, count=0; following cycle inst_pc=32'h40.
//   T4 RESET_PC=32'hFFFF_FFFE, ready=1 -> inst_pc FFFFFFFE, FFFFFFFF, 0, 1.
//   T5 rst_n pulsed low mid-stream (asynchronous, between edges) with count=3 ->
//      inst_valid drops immediately, imem_addr=RESET_PC; fetch resumes from RESET_PC.
//   T6 en=0 after 2 pushes, ready=1 -> both entries drain, no further push, pc held at 2;
//      en=1 -> fetch resumes at pc=2.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads one word per cycle, queues {pc, word} for decode.
// Latency: en seen at edge N -> first push at N+1; redirect at M -> target visible after M+1.
// Backpressure: inst_ready low fills the prefetch FIFO; when full, fetch stalls with the PC held.
// Ports: clk/rst_n (async active-low); en; imem_addr/imem_data (memory read, word address);
//        redirect/redirect_pc (flush and restart); inst_valid/inst_ready/inst/inst_pc (to decode);
//        fifo_count (occupied prefetch entries).
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic          full, push, pop;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = (state == FETCH) & ~redirect & (~full | pop);

  assign imem_addr  = pc;
  assign fifo_count = count;
  // Storage is not reset; gating on valid keeps the outputs at zero when empty.
  assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = en ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = FETCH;
        FETCH:   if (!en) state_nxt = IDLE;
                 else if (full && !pop) state_nxt = STALL;
        STALL:   if (!en) state_nxt = IDLE;
                 else if (pop) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc     <= redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd1;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_data;
      mem_pc[wr_ptr]   <= pc;
    end
  end

endmodule
